// File: rtl/mem_io_pkg.sv
// Shared types and defaults for the CPU memory/IO bridge.
// Decode results classify each IO word index as output, input, button or unmapped.
package mem_io_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;
  localparam int          BTN_IDX_DEFAULT = 15;

  typedef logic [3:0] io_idx_t;

  typedef enum logic [1:0] {
    IO_NONE,
    IO_OUT,
    IO_IN,
    IO_BTN
  } io_kind_e;

endpackage

// File: rtl/mem_io_bridge_btn_event_capture.sv
// Button synchroniser, rising-edge detector and sticky pending bits.
// A clear and a new edge in the same cycle leave the bit set.
module btn_event_capture #(
  parameter int N_BTN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] clr,
  output logic [N_BTN-1:0] pending
);

  logic [N_BTN-1:0] s1_reg;
  logic [N_BTN-1:0] s2_reg;
  logic [N_BTN-1:0] hist_reg;
  logic [N_BTN-1:0] pending_reg;
  logic [N_BTN-1:0] pending_next;
  logic [N_BTN-1:0] rise;

  assign rise         = s2_reg & ~hist_reg;
  assign pending_next = (pending_reg & ~clr) | rise;
  assign pending      = pending_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg      <= '0;
      s2_reg      <= '0;
      hist_reg    <= '0;
      pending_reg <= '0;
    end else begin
      s1_reg      <= btn_in;
      s2_reg      <= s1_reg;
      hist_reg    <= s2_reg;
      pending_reg <= pending_next;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Memory/IO bridge for the single-cycle core: address decode, read-data steering,
// peripheral output registers, synchronised inputs and button events.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int          N_OUT   = 4,
  parameter int          OUT_W   = 16,
  parameter logic [31:0] OUT_RST = '0,
  parameter int          N_IN    = 4,
  parameter int          IN_W    = 16,
  parameter int          N_BTN   = 4,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int          BTN_IDX = BTN_IDX_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   io_read,
  input  logic                   io_write,
  input  logic [31:0]            addr_in,
  input  logic [31:0]            m_rdata,
  input  logic [31:0]            r_rdata,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic [N_BTN-1:0]       btn_in,
  output logic [31:0]            addr_out,
  output logic [31:0]            m_wdata,
  output logic                   m_we,
  output logic [31:0]            r_wdata,
  output logic [N_OUT*OUT_W-1:0] out_data,
  output logic [N_OUT-1:0]       out_we,
  output logic [N_BTN-1:0]       btn_pending,
  output logic                   bus_err
);

  if (N_OUT > BTN_IDX) begin : g_bad_n_out
    $error("N_OUT must not exceed BTN_IDX");
  end
  if (N_IN > BTN_IDX) begin : g_bad_n_in
    $error("N_IN must not exceed BTN_IDX");
  end
  if (OUT_W > 32 || IN_W > 32 || N_BTN > 32) begin : g_bad_width
    $error("OUT_W, IN_W and N_BTN must be at most 32");
  end
  if (BTN_IDX > 15) begin : g_bad_btn_idx
    $error("BTN_IDX must fit the 4-bit word index");
  end

  logic                 io_hit;
  logic                 mem_acc;
  logic                 io_rd;
  logic                 io_wr;
  io_idx_t              idx;
  io_kind_e             kind;
  logic [N_IN*IN_W-1:0] in_s1_reg;
  logic [N_IN*IN_W-1:0] in_s2_reg;
  logic [N_BTN-1:0]     btn_clr;
  logic                 bus_err_reg;

  assign io_hit  = (addr_in[31:10] == IO_BASE[31:10]);
  assign idx     = addr_in[5:2];
  // Any memory strobe suppresses the IO side entirely.
  assign mem_acc = mem_read | mem_write;
  assign io_rd   = io_read & io_hit & ~mem_acc;
  assign io_wr   = io_write & io_hit & ~mem_acc;

  assign addr_out = addr_in;
  assign m_wdata  = r_rdata;
  assign m_we     = mem_write;

  always_comb begin
    kind = IO_NONE;
    if (idx == io_idx_t'(BTN_IDX))
      kind = IO_BTN;
    else if (io_wr && int'(idx) < N_OUT)
      kind = IO_OUT;
    else if (io_rd && int'(idx) < N_IN)
      kind = IO_IN;
  end

  always_comb begin
    r_wdata = '0;
    if (mem_read) begin
      r_wdata = m_rdata;
    end else if (io_rd && kind == IO_IN) begin
      for (int k = 0; k < N_IN; k++) begin
        if (int'(idx) == k)
          r_wdata[IN_W-1:0] = in_s2_reg[k*IN_W +: IN_W];
      end
    end else if (io_rd && kind == IO_BTN) begin
      r_wdata[N_BTN-1:0] = btn_pending;
    end
  end

  always_comb begin
    btn_clr = '0;
    if (io_rd && kind == IO_BTN)
      btn_clr = {N_BTN{1'b1}};
    else if (io_wr && kind == IO_BTN)
      btn_clr = r_rdata[N_BTN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_s1_reg   <= '0;
      in_s2_reg   <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      in_s1_reg   <= in_data;
      in_s2_reg   <= in_s1_reg;
      bus_err_reg <= (io_rd | io_wr) && kind == IO_NONE;
    end
  end

  assign bus_err = bus_err_reg;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    logic [OUT_W-1:0] data_reg;
    logic             we_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg <= OUT_RST[OUT_W-1:0];
        we_reg   <= 1'b0;
      end else begin
        we_reg <= 1'b0;
        if (kind == IO_OUT && int'(idx) == gi) begin
          data_reg <= r_rdata[OUT_W-1:0];
          we_reg   <= 1'b1;
        end
      end
    end

    assign out_data[gi*OUT_W +: OUT_W] = data_reg;
    assign out_we[gi]                  = we_reg;
  end

  btn_event_capture #(
    .N_BTN(N_BTN)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (btn_in),
    .clr    (btn_clr),
    .pending(btn_pending)
  );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: expectations are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_mem_io_bridge;

  localparam int          N_OUT    = 4;
  localparam int          OUT_W    = 16;
  localparam int          N_IN     = 4;
  localparam int          IN_W     = 16;
  localparam int          N_BTN    = 4;
  localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;
  localparam logic [31:0] BTN_ADDR = IO_BASE + 32'h3C;

  logic                   clk;
  logic                   rst_n;
  logic                   mem_read, mem_write, io_read, io_write;
  logic [31:0]            addr_in, m_rdata, r_rdata;
  logic [N_IN*IN_W-1:0]   in_data;
  logic [N_BTN-1:0]       btn_in;
  logic [31:0]            addr_out, m_wdata, r_wdata;
  logic                   m_we;
  logic [N_OUT*OUT_W-1:0] out_data;
  logic [N_OUT-1:0]       out_we;
  logic [N_BTN-1:0]       btn_pending;
  logic                   bus_err;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [63:0] got;
  logic [63:0] exp_out;
  int          vectors     = 0;
  int          miscompares = 0;

  mem_io_bridge #(
    .N_OUT(N_OUT), .OUT_W(OUT_W), .OUT_RST(32'h0), .N_IN(N_IN), .IN_W(IN_W),
    .N_BTN(N_BTN), .IO_BASE(IO_BASE), .BTN_IDX(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read), .io_write(io_write),
    .addr_in(addr_in), .m_rdata(m_rdata), .r_rdata(r_rdata),
    .in_data(in_data), .btn_in(btn_in),
    .addr_out(addr_out), .m_wdata(m_wdata), .m_we(m_we), .r_wdata(r_wdata),
    .out_data(out_data), .out_we(out_we), .btn_pending(btn_pending), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    io_read   = 1'b0;
    io_write  = 1'b0;
    addr_in   = 32'h0;
    m_rdata   = 32'h0;
    r_rdata   = 32'h0;
  endtask

  task automatic test_reset_state();
    rst_n   = 1'b0;
    in_data = '0;
    btn_in  = '0;
    idle();
    exp_out = '0;
    repeat (3) tick();
    sb.push_back('{"rst_out_data", 64'h0});
    sb.push_back('{"rst_flags", 64'h0});
    rst_n = 1'b1;
    tick();
    e = sb.pop_front(); got = 64'(out_data); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    e = sb.pop_front(); got = {55'h0, bus_err, out_we, btn_pending}; vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_io_write();
    io_write = 1'b1;
    addr_in  = IO_BASE + 32'h4;
    r_rdata  = 32'h0000_A5A5;
    exp_out[16 +: 16] = 16'hA5A5;
    sb.push_back('{"wr_out_we", 64'b0010});
    sb.push_back('{"wr_out_data", exp_out});
    sb.push_back('{"wr_we_drop", 64'b0000});
    sb.push_back('{"wr_hold_data", exp_out});
    tick();
    idle();
    e = sb.pop_front(); got = 64'(out_we); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    e = sb.pop_front(); got = 64'(out_data); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    tick();
    e = sb.pop_front(); got = 64'(out_we); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    e = sb.pop_front(); got = 64'(out_data); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_back_to_back();
    int          chans[4];
    logic [15:0] d;
    chans = '{0, 2, 3, 2};
    for (int i = 0; i < 4; i++) begin
      d        = 16'($urandom_range(0, 16'hFFFF));
      io_write = 1'b1;
      addr_in  = IO_BASE + 32'(chans[i] * 4);
      r_rdata  = {16'($urandom), d};
      exp_out[chans[i]*16 +: 16] = d;
      sb.push_back('{"b2b_out_we", 64'(1) << chans[i]});
      sb.push_back('{"b2b_out_data", exp_out});
      tick();
      e = sb.pop_front(); got = 64'(out_we); vectors++;
      if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
      e = sb.pop_front(); got = 64'(out_data); vectors++;
      if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    end
    idle();
    tick();
  endtask

  task automatic test_sync_latency();
    in_data = 64'h0000_1234_0000_0000;
    io_read = 1'b1;
    addr_in = IO_BASE + 32'h8;
    for (int k = 0; k < 4; k++)
      sb.push_back('{$sformatf("sync_edge%0d", k), (k >= 2) ? 64'h1234 : 64'h0});
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      #1;
      e = sb.pop_front(); got = 64'(r_wdata); vectors++;
      if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    end
    idle();
    tick();
  endtask

  task automatic test_button();
    btn_in = 4'b1000;
    sb.push_back('{"btn_edge1", 64'h0});
    sb.push_back('{"btn_edge2", 64'h0});
    sb.push_back('{"btn_edge3", 64'h8});
    for (int k = 0; k < 3; k++) begin
      tick();
      e = sb.pop_front(); got = 64'(btn_pending); vectors++;
      if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    end
    btn_in = 4'b0000;
    repeat (3) tick();
    io_read = 1'b1;
    addr_in = BTN_ADDR;
    sb.push_back('{"btn_read_data", 64'h8});
    sb.push_back('{"btn_read_clear", 64'h0});
    #1;
    e = sb.pop_front(); got = 64'(r_wdata); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    tick();
    idle();
    e = sb.pop_front(); got = 64'(btn_pending); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    // New press timed so its edge lands in the same cycle as a read-to-clear.
    btn_in = 4'b1000;
    tick();
    tick();
    io_read = 1'b1;
    addr_in = BTN_ADDR;
    sb.push_back('{"btn_collide_kept", 64'h8});
    tick();
    idle();
    e = sb.pop_front(); got = 64'(btn_pending); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    btn_in = 4'b0000;
    repeat (3) tick();
    io_read = 1'b1;
    addr_in = BTN_ADDR;
    tick();
    idle();
  endtask

  task automatic test_w1c();
    btn_in = 4'b0111;
    repeat (3) tick();
    btn_in = 4'b0000;
    repeat (3) tick();
    sb.push_back('{"w1c_before", 64'h7});
    sb.push_back('{"w1c_after", 64'h2});
    sb.push_back('{"w1c_no_err", 64'h0});
    e = sb.pop_front(); got = 64'(btn_pending); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    io_write = 1'b1;
    addr_in  = BTN_ADDR;
    r_rdata  = 32'h5;
    tick();
    idle();
    e = sb.pop_front(); got = 64'(btn_pending); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    e = sb.pop_front(); got = {59'h0, bus_err, out_we}; vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_priority();
    mem_read = 1'b1;
    io_read  = 1'b1;
    addr_in  = IO_BASE + 32'h24;
    m_rdata  = 32'hDEAD_BEEF;
    sb.push_back('{"prio_rdata", 64'hDEAD_BEEF});
    sb.push_back('{"prio_no_err", 64'h0});
    #1;
    e = sb.pop_front(); got = 64'(r_wdata); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    tick();
    idle();
    e = sb.pop_front(); got = 64'(bus_err); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    // Store to memory while io_write targets channel 0: memory path only.
    mem_write = 1'b1;
    io_write  = 1'b1;
    addr_in   = IO_BASE;
    r_rdata   = 32'hCAFE_1234;
    sb.push_back('{"mem_path", {IO_BASE, 32'hCAFE_1234}});
    sb.push_back('{"mem_we", 64'h1});
    sb.push_back('{"mem_io_ignored", {exp_out[59:0], 4'b0000}});
    #1;
    e = sb.pop_front(); got = {addr_out, m_wdata}; vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    e = sb.pop_front(); got = 64'(m_we); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    tick();
    idle();
    e = sb.pop_front(); got = {out_data[59:0], out_we}; vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_error();
    io_write = 1'b1;
    addr_in  = IO_BASE + 32'h24;
    r_rdata  = 32'hFFFF_FFFF;
    sb.push_back('{"err_wr_pulse", {exp_out[58:0], 1'b1, 4'b0000}});
    sb.push_back('{"err_wr_drop", 64'h0});
    tick();
    idle();
    e = sb.pop_front(); got = {out_data[58:0], bus_err, out_we}; vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    tick();
    e = sb.pop_front(); got = 64'(bus_err); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    io_read = 1'b1;
    addr_in = IO_BASE + 32'h1C;
    sb.push_back('{"err_rd_data", 64'h0});
    sb.push_back('{"err_rd_pulse", 64'h1});
    #1;
    e = sb.pop_front(); got = 64'(r_wdata); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    tick();
    idle();
    e = sb.pop_front(); got = 64'(bus_err); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    io_read = 1'b1;
    addr_in = 32'h0000_0008;
    sb.push_back('{"non_io_read", 64'h0});
    tick();
    idle();
    e = sb.pop_front(); got = {r_wdata, 31'h0, bus_err}; vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  task automatic test_reset();
    btn_in = 4'b0001;
    repeat (3) tick();
    btn_in   = 4'b0000;
    io_write = 1'b1;
    addr_in  = IO_BASE + 32'h20;
    tick();
    io_write = 1'b1;
    addr_in  = IO_BASE;
    r_rdata  = 32'h0000_7777;
    exp_out  = '0;
    sb.push_back('{"rst_mid_data", 64'h0});
    sb.push_back('{"rst_mid_flags", 64'h0});
    sb.push_back('{"rst_hold_data", 64'h0});
    sb.push_back('{"rst_release_flags", 64'h0});
    #2 rst_n = 1'b0;
    #1;
    e = sb.pop_front(); got = 64'(out_data); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    e = sb.pop_front(); got = {55'h0, bus_err, out_we, btn_pending}; vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    tick();
    idle();
    rst_n = 1'b1;
    repeat (2) tick();
    e = sb.pop_front(); got = 64'(out_data); vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
    e = sb.pop_front(); got = {55'h0, bus_err, out_we, btn_pending}; vectors++;
    if (got !== e.val) begin miscompares++; $display("FAIL %s: got %h, expected %h", e.name, got, e.val); end
  endtask

  initial begin
    test_reset_state();
    test_io_write();
    test_back_to_back();
    test_sync_latency();
    test_button();
    test_w1c();
    test_priority();
    test_error();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
